// File: rtl/mem_stage_pkg.sv
// Shared types and widths for the memory stage of the 22-bit pipeline.
// Holds the writeback bundle carried across the MEM/WB boundary.
package mem_stage_pkg;

  localparam int DATA_W = 22;
  localparam int REG_W  = 4;

  typedef enum logic {
    IDLE,
    ACCESS
  } mem_state_t;

  typedef struct packed {
    logic              pc_src;
    logic              reg_write;
    logic              mem_reg;
    logic [DATA_W-1:0] read_data;
    logic [DATA_W-1:0] alu_result;
    logic [REG_W-1:0]  write_register;
  } wb_bundle_t;

endpackage

// File: rtl/mem_wb_register.sv
// MEM/WB pipeline register; a bubble clears the control bits and
// leaves the data fields at their previous values.
import mem_stage_pkg::*;

module mem_wb_register (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_bubble,
  input  wb_bundle_t i_d,
  output wb_bundle_t o_q
);

  wb_bundle_t r_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= '0;
    end else if (i_bubble) begin
      r_q.pc_src    <= 1'b0;
      r_q.reg_write <= 1'b0;
      r_q.mem_reg   <= 1'b0;
    end else begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/memory_stage.sv
// Memory stage: issues data-memory accesses over req/ack, stalls
// upstream while outstanding, and aborts after TIMEOUT cycles.
import mem_stage_pkg::*;

module memory_stage #(
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pc_src_m,
  input  logic              reg_write_m,
  input  logic              mem_reg_m,
  input  logic              mem_write_m,
  input  logic [DATA_W-1:0] alu_result_m,
  input  logic [DATA_W-1:0] write_data_m,
  input  logic [REG_W-1:0]  write_register_m,
  output logic              stall_m,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              pc_src_w,
  output logic              reg_write_w,
  output logic              mem_reg_w,
  output logic [DATA_W-1:0] read_data_w,
  output logic [DATA_W-1:0] alu_result_w,
  output logic [REG_W-1:0]  write_register_w,
  output logic              mem_error
);

  localparam logic [7:0] LP_TO = 8'(TIMEOUT);

  mem_state_t        r_state, w_state_n;
  logic [7:0]        r_cnt, w_cnt_n;
  logic              r_req, w_req_n;
  logic              r_we, w_we_n;
  logic              r_err, w_err_n;
  logic [DATA_W-1:0] r_addr, w_addr_n;
  logic [DATA_W-1:0] r_wdata, w_wdata_n;
  logic              r_pc, w_pc_n;
  logic              r_rw, w_rw_n;
  logic              r_mr, w_mr_n;
  logic [REG_W-1:0]  r_wreg, w_wreg_n;
  logic              w_memop, w_timeout, w_bubble, w_stall;
  wb_bundle_t        w_wb_d, w_wb_q;

  assign w_memop   = mem_write_m | (mem_reg_m & reg_write_m);
  assign w_timeout = (r_cnt == LP_TO);

  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_req_n   = r_req;
    w_we_n    = r_we;
    w_err_n   = r_err;
    w_addr_n  = r_addr;
    w_wdata_n = r_wdata;
    w_pc_n    = r_pc;
    w_rw_n    = r_rw;
    w_mr_n    = r_mr;
    w_wreg_n  = r_wreg;
    w_stall   = 1'b0;
    w_bubble  = 1'b1;
    w_wb_d    = w_wb_q;
    unique case (r_state)
      IDLE: begin
        if (w_memop) begin
          w_stall   = 1'b1;
          w_addr_n  = alu_result_m;
          w_wdata_n = write_data_m;
          w_we_n    = mem_write_m;
          w_pc_n    = pc_src_m;
          w_rw_n    = reg_write_m;
          w_mr_n    = mem_reg_m;
          w_wreg_n  = write_register_m;
          w_req_n   = 1'b1;
          // counter tracks the ACCESS cycle number, 1-based
          w_cnt_n   = 8'd1;
          w_state_n = ACCESS;
        end else begin
          w_bubble                = 1'b0;
          w_wb_d.pc_src           = pc_src_m;
          w_wb_d.reg_write        = reg_write_m;
          w_wb_d.mem_reg          = mem_reg_m;
          w_wb_d.alu_result       = alu_result_m;
          w_wb_d.write_register   = write_register_m;
        end
      end
      ACCESS: begin
        if (mem_ack || w_timeout) begin
          w_bubble              = 1'b0;
          w_wb_d.mem_reg        = r_mr;
          w_wb_d.alu_result     = r_addr;
          w_wb_d.write_register = r_wreg;
          w_wb_d.pc_src         = mem_ack & r_pc;
          w_wb_d.reg_write      = mem_ack & r_rw;
          if (mem_ack && !r_we) w_wb_d.read_data = mem_rdata;
          if (!mem_ack) w_err_n = 1'b1;
          w_req_n   = 1'b0;
          w_cnt_n   = 8'd0;
          w_state_n = IDLE;
        end else begin
          w_stall = 1'b1;
          w_cnt_n = r_cnt + 8'd1;
        end
      end
      default: w_state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_err   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_pc    <= 1'b0;
      r_rw    <= 1'b0;
      r_mr    <= 1'b0;
      r_wreg  <= '0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_req   <= w_req_n;
      r_we    <= w_we_n;
      r_err   <= w_err_n;
      r_addr  <= w_addr_n;
      r_wdata <= w_wdata_n;
      r_pc    <= w_pc_n;
      r_rw    <= w_rw_n;
      r_mr    <= w_mr_n;
      r_wreg  <= w_wreg_n;
    end
  end

  mem_wb_register u_mem_wb (
    .clk      (clk),
    .rst      (rst),
    .i_bubble (w_bubble),
    .i_d      (w_wb_d),
    .o_q      (w_wb_q)
  );

  assign stall_m          = w_stall;
  assign mem_req          = r_req;
  assign mem_we           = r_we;
  assign mem_addr         = r_addr;
  assign mem_wdata        = r_wdata;
  assign mem_error        = r_err;
  assign pc_src_w         = w_wb_q.pc_src;
  assign reg_write_w      = w_wb_q.reg_write;
  assign mem_reg_w        = w_wb_q.mem_reg;
  assign read_data_w      = w_wb_q.read_data;
  assign alu_result_w     = w_wb_q.alu_result;
  assign write_register_w = w_wb_q.write_register;

endmodule

// File: tb/tb_memory_stage.sv
// Bench for memory_stage: pass-through table, directed memory-op
// sequences, then random traffic against a transaction-level model.
module tb_memory_stage;

  localparam int DW = 22;
  localparam int RW = 4;
  localparam int TO = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic          pc_src_m, reg_write_m, mem_reg_m, mem_write_m;
  logic [DW-1:0] alu_result_m, write_data_m, mem_rdata;
  logic [RW-1:0] write_register_m;
  logic          stall_m, mem_req, mem_we, mem_ack;
  logic [DW-1:0] mem_addr, mem_wdata;
  logic          pc_src_w, reg_write_w, mem_reg_w, mem_error;
  logic [DW-1:0] read_data_w, alu_result_w;
  logic [RW-1:0] write_register_w;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  memory_stage #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .pc_src_m(pc_src_m), .reg_write_m(reg_write_m),
    .mem_reg_m(mem_reg_m), .mem_write_m(mem_write_m),
    .alu_result_m(alu_result_m), .write_data_m(write_data_m),
    .write_register_m(write_register_m),
    .stall_m(stall_m), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .pc_src_w(pc_src_w), .reg_write_w(reg_write_w),
    .mem_reg_w(mem_reg_w), .read_data_w(read_data_w),
    .alu_result_w(alu_result_w),
    .write_register_w(write_register_w),
    .mem_error(mem_error)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic pc, input logic rw, input logic mr,
                       input logic mw, input logic [DW-1:0] alu,
                       input logic [DW-1:0] wd, input logic [RW-1:0] wr);
    pc_src_m = pc; reg_write_m = rw; mem_reg_m = mr; mem_write_m = mw;
    alu_result_m = alu; write_data_m = wd; write_register_m = wr;
  endtask

  typedef struct {
    logic          pc, rw, mr;
    logic [DW-1:0] alu;
    logic [RW-1:0] wr;
  } vec_t;

  vec_t vecs[4];

  // transaction-level reference state
  typedef struct {
    logic          pc, rw, mr, mw;
    logic [DW-1:0] alu, wd;
    logic [RW-1:0] wr;
  } op_t;

  op_t           cur, pend;
  bit            busy, prev_stall, es, memop;
  int            age, ack_at, n;
  logic          e_req, e_we, e_pc, e_rw, e_mr, e_err;
  logic [DW-1:0] e_addr, e_wdata, e_rd, e_alu;
  logic [RW-1:0] e_wr;
  logic [31:0]   r32;

  initial begin
    rst = 1'b1; mem_ack = 1'b0; mem_rdata = '0;
    drive(0, 0, 0, 0, '0, '0, '0);
    tick(); tick();
    chk("rst_req", 32'(mem_req), 0);
    chk("rst_rw", 32'(reg_write_w), 0);
    chk("rst_alu", 32'(alu_result_w), 0);
    chk("rst_err", 32'(mem_error), 0);
    chk("rst_addr", 32'(mem_addr), 0);
    rst = 1'b0;

    vecs[0] = '{1'b0, 1'b1, 1'b0, 22'h00ABC, 4'h3};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 22'h3FFFF, 4'hF};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 22'h00055, 4'h8};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 22'h00000, 4'h1};
    foreach (vecs[i]) begin
      drive(vecs[i].pc, vecs[i].rw, vecs[i].mr, 0, vecs[i].alu,
            22'h1, vecs[i].wr);
      #2 chk("tbl_stall", 32'(stall_m), 0);
      tick();
      chk("tbl_pc", 32'(pc_src_w), 32'(vecs[i].pc));
      chk("tbl_rw", 32'(reg_write_w), 32'(vecs[i].rw));
      chk("tbl_mr", 32'(mem_reg_w), 32'(vecs[i].mr));
      chk("tbl_alu", 32'(alu_result_w), 32'(vecs[i].alu));
      chk("tbl_wr", 32'(write_register_w), 32'(vecs[i].wr));
      chk("tbl_req", 32'(mem_req), 0);
      chk("tbl_rd", 32'(read_data_w), 0);
    end

    // load acked on the 4th ACCESS cycle
    drive(0, 1, 1, 0, 22'h00010, 22'h0, 4'h5);
    n = 0;
    for (int c = 0; c < 4; c++) begin
      #2 if (stall_m) n++;
      if (c > 0) begin
        chk("ld_addr", 32'(mem_addr), 32'h10);
        chk("ld_req", 32'(mem_req), 1);
        chk("ld_bub", 32'(reg_write_w), 0);
      end
      tick();
    end
    mem_ack = 1'b1; mem_rdata = 22'h12345;
    #2 chk("ld_ack_stall", 32'(stall_m), 0);
    chk("ld_addr_ack", 32'(mem_addr), 32'h10);
    tick();
    mem_ack = 1'b0;
    drive(0, 0, 0, 0, '0, '0, '0);
    chk("ld_stall_cnt", 32'(n), 4);
    chk("ld_rd", 32'(read_data_w), 32'h12345);
    chk("ld_rw", 32'(reg_write_w), 1);
    chk("ld_wr", 32'(write_register_w), 5);
    chk("ld_req_off", 32'(mem_req), 0);

    // store acked on the 2nd ACCESS cycle
    drive(0, 0, 0, 1, 22'h00020, 22'h3FFFF, 4'h7);
    tick();
    chk("st_we", 32'(mem_we), 1);
    chk("st_wdata", 32'(mem_wdata), 32'h3FFFF);
    tick();
    mem_ack = 1'b1; mem_rdata = 22'h2AAAA;
    tick();
    mem_ack = 1'b0;
    drive(0, 0, 0, 0, '0, '0, '0);
    chk("st_alu", 32'(alu_result_w), 32'h20);
    chk("st_rw", 32'(reg_write_w), 0);
    chk("st_rd_keep", 32'(read_data_w), 32'h12345);

    // timeout: no ack ever
    drive(1, 1, 1, 0, 22'h00030, 22'h0, 4'h9);
    tick();
    n = 0;
    while (mem_req && n < 40) begin n++; tick(); end
    drive(0, 1, 0, 0, 22'h00ABC, 22'h0, 4'h2);
    chk("to_cycles", 32'(n), 32'(TO));
    chk("to_err", 32'(mem_error), 1);
    chk("to_rw", 32'(reg_write_w), 0);
    chk("to_pc", 32'(pc_src_w), 0);
    chk("to_alu", 32'(alu_result_w), 32'h30);
    #2 chk("to_next_stall", 32'(stall_m), 0);
    tick();
    chk("to_next_rw", 32'(reg_write_w), 1);
    chk("to_next_alu", 32'(alu_result_w), 32'hABC);
    chk("to_sticky", 32'(mem_error), 1);

    // reset in the middle of an access, late ack afterwards
    drive(0, 1, 1, 0, 22'h00040, 22'h0, 4'h4);
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(0, 0, 0, 0, '0, '0, '0);
    mem_ack = 1'b1; mem_rdata = 22'h1F0F0;
    chk("mr_req", 32'(mem_req), 0);
    chk("mr_err", 32'(mem_error), 0);
    chk("mr_rd", 32'(read_data_w), 0);
    tick();
    mem_ack = 1'b0;
    chk("mr_late_rd", 32'(read_data_w), 0);
    chk("mr_late_rw", 32'(reg_write_w), 0);
    chk("mr_late_req", 32'(mem_req), 0);

    // random traffic against the reference model
    rst = 1'b1; tick(); rst = 1'b0;
    busy = 0; prev_stall = 0; age = 0; ack_at = 0;
    e_req = 0; e_we = 0; e_pc = 0; e_rw = 0; e_mr = 0; e_err = 0;
    e_addr = '0; e_wdata = '0; e_rd = '0; e_alu = '0; e_wr = '0;
    cur = '{default: '0}; pend = '{default: '0};
    for (int c = 0; c < 600; c++) begin
      if (!prev_stall) begin
        r32 = $urandom;
        cur.pc = r32[0]; cur.rw = r32[1]; cur.wr = r32[7:4];
        cur.mr = 0; cur.mw = 0;
        unique case (r32[9:8])
          2'd0: ;
          2'd1: begin cur.mr = 1; cur.rw = 1; end
          2'd2: cur.mw = 1;
          default: begin cur.mr = 1; cur.rw = 0; end
        endcase
        r32 = $urandom; cur.alu = r32[DW-1:0];
        r32 = $urandom; cur.wd = r32[DW-1:0];
        ack_at = $urandom_range(1, TO + 2);
        drive(cur.pc, cur.rw, cur.mr, cur.mw, cur.alu, cur.wd, cur.wr);
      end
      mem_ack = busy ? (age == ack_at) : ($urandom_range(0, 7) == 0);
      r32 = $urandom; mem_rdata = r32[DW-1:0];
      memop = cur.mw | (cur.mr & cur.rw);
      es = busy ? !(mem_ack || age == TO) : memop;
      #2 chk("rnd_stall", 32'(stall_m), 32'(es));
      if (!busy && memop) begin
        pend = cur; busy = 1; age = 1;
        e_req = 1; e_we = cur.mw; e_addr = cur.alu; e_wdata = cur.wd;
        e_pc = 0; e_rw = 0; e_mr = 0;
      end else if (!busy) begin
        e_pc = cur.pc; e_rw = cur.rw; e_mr = cur.mr;
        e_alu = cur.alu; e_wr = cur.wr;
      end else if (mem_ack || age == TO) begin
        busy = 0; e_req = 0;
        e_alu = pend.alu; e_wr = pend.wr; e_mr = pend.mr;
        e_pc = mem_ack & pend.pc; e_rw = mem_ack & pend.rw;
        if (mem_ack && !pend.mw) e_rd = mem_rdata;
        if (!mem_ack) e_err = 1;
      end else begin
        age++; e_pc = 0; e_rw = 0; e_mr = 0;
      end
      prev_stall = es;
      tick();
      chk("rnd_req", 32'(mem_req), 32'(e_req));
      chk("rnd_we", 32'(mem_we), 32'(e_we));
      chk("rnd_addr", 32'(mem_addr), 32'(e_addr));
      chk("rnd_wdata", 32'(mem_wdata), 32'(e_wdata));
      chk("rnd_pc", 32'(pc_src_w), 32'(e_pc));
      chk("rnd_rw", 32'(reg_write_w), 32'(e_rw));
      chk("rnd_mr", 32'(mem_reg_w), 32'(e_mr));
      chk("rnd_rd", 32'(read_data_w), 32'(e_rd));
      chk("rnd_alu", 32'(alu_result_w), 32'(e_alu));
      chk("rnd_wr", 32'(write_register_w), 32'(e_wr));
      chk("rnd_err", 32'(mem_error), 32'(e_err));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/memory_stage.md
Name: memory_stage

Overview:
- Consumes the execute-to-memory pipeline signals (ALU result as address, store data, destination register, qualified control bits).
- Performs data-memory accesses through a req/ack handshake, stalling upstream while an access is outstanding.
- Registers the results into the memory-to-writeback pipeline boundary.
- Sits between the execute stage and the writeback/register-file logic of the 22-bit pipeline.

Parameters:
- DATA_W, 22, datapath and address width
- REG_W, 4, register-index width
- TIMEOUT, 15, maximum cycles mem_req waits for mem_ack before abort (1..255)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- pc_src_m  in  1  branch/PC-write flag from execute (already condition-qualified)
- reg_write_m  in  1  register write enable (condition-qualified)
- mem_reg_m  in  1  writeback selects memory data (load)
- mem_write_m  in  1  store enable (condition-qualified)
- alu_result_m  in  DATA_W  address for memory ops, result otherwise
- write_data_m  in  DATA_W  store data
- write_register_m  in  REG_W  destination register
- stall_m  out  1  combinational; upstream holds all *_m inputs while high
- mem_req  out  1  registered access request
- mem_we  out  1  registered, 1 = store
- mem_addr  out  DATA_W  registered address
- mem_wdata  out  DATA_W  registered store data
- mem_rdata  in  DATA_W  load data, valid with mem_ack
- mem_ack  in  1  single-cycle completion strobe
- pc_src_w, reg_write_w, mem_reg_w  out  1 each  registered writeback controls
- read_data_w  out  DATA_W  registered load data
- alu_result_w  out  DATA_W  registered ALU result
- write_register_w  out  REG_W  registered destination
- mem_error  out  1  sticky timeout flag

Behaviour:
- Reset: all outputs 0, state IDLE, timeout counter 0, mem_error 0. Reset mid-access drops mem_req the next cycle; a late mem_ack is ignored.
- memop = mem_write_m | (mem_reg_m & reg_write_m). A load whose reg_write_m is 0 is not issued; it passes as a non-memory op.
- IDLE, !memop:
  - Single-cycle pass-through; W registers load the *_m values; read_data_w holds its previous value.
  - stall_m = 0.
- IDLE, memop:
  - stall_m = 1.
  - Latch mem_addr = alu_result_m, mem_wdata = write_data_m, mem_we = mem_write_m, plus controls and destination.
  - mem_req <= 1; go to ACCESS.
  - W registers load a bubble (all controls 0).
- ACCESS, no mem_ack:
  - mem_req, mem_addr, mem_wdata and mem_we are held stable.
  - Counter increments; stall_m = 1; W loads a bubble.
- ACCESS, mem_ack:
  - stall_m = 0 that cycle, so upstream advances next cycle.
  - W registers load the latched controls/destination/address; read_data_w = mem_rdata (loads only; stores keep the previous value).
  - mem_req <= 0; counter clears; go to IDLE.
  - Exactly one W update per memory op; minimum memory-op latency is 2 cycles (issue + ack).
- ACCESS, counter == TIMEOUT with no ack:
  - mem_req <= 0; mem_error <= 1 (sticky until rst).
  - W loads the op with reg_write_w = 0 and pc_src_w = 0 (squashed).
  - stall_m = 0; return to IDLE.
- mem_ack is ignored in IDLE. mem_ack and timeout in the same cycle: the ack wins.
- Counter is 8 bits and never wraps past TIMEOUT.
- Back-to-back memory ops: after the ack cycle, the next op is seen in IDLE and issued the following cycle. There is one idle cycle on mem_req between accesses.

Decomposition:
- Package mem_stage_pkg:
  - DATA_W and REG_W constants.
  - mem_state_t enum {IDLE, ACCESS}.
  - Packed struct wb_bundle_t carrying pc_src, reg_write, mem_reg, read_data, alu_result, write_register.
- One sub-module, mem_wb_register:
  - Clocked wb_bundle_t register with synchronous rst and a bubble input that forces the control bits to 0.

Test Plan:
- Non-mem op: reg_write_m=1, alu_result_m=22'h00ABC, write_register_m=4'h3 -> next cycle reg_write_w=1, alu_result_w=22'h00ABC, write_register_w=3; stall_m never high.
- Load: mem_reg_m=reg_write_m=1, alu_result_m=22'h00010, ack after 3 cycles with mem_rdata=22'h12345:
  - stall_m is high 4 cycles; mem_addr=22'h00010 stable throughout.
  - read_data_w=22'h12345 and reg_write_w=1 the cycle after the ack.
- Store: mem_write_m=1, alu_result_m=22'h00020, write_data_m=22'h3FFFF, ack after 1 cycle:
  - mem_we=1, mem_wdata=22'h3FFFF.
  - One W update with reg_write_w=0.
- Load with reg_write_m=0: no mem_req; one-cycle pass-through.
- Timeout: TIMEOUT=15, no ack:
  - mem_req deasserts after 15 ACCESS cycles; mem_error=1 and stays 1.
  - W sees reg_write_w=0; the next op proceeds normally.
- rst asserted during ACCESS:
  - All outputs 0 the next cycle.
  - mem_ack arriving the cycle after reset produces no W update.
